// File: rtl/nn_perturb_train_ctrl.sv
// nn_perturb_train_ctrl: weight-perturbation training sequencer owning the neuron weight bank
module nn_perturb_train_ctrl #(
  parameter int WIDTH   = 8,
  parameter int N_W     = 10,
  parameter int LOSS_W  = 42,
  parameter int FWD_LAT = 4,
  parameter int STEP    = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [7:0]           iters_i,
  input  logic                 init_load_i,
  input  logic [3:0]           init_idx_i,
  input  logic [WIDTH-1:0]     init_w_i,
  input  logic [LOSS_W-1:0]    loss_i,
  output logic                 fwd_en_o,
  output logic [N_W*WIDTH-1:0] w_flat_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [LOSS_W-1:0]    best_loss_o,
  output logic [7:0]           iter_o
);
  localparam int K_W = $clog2(N_W);
  localparam int C_W = $clog2(FWD_LAT + 1);
  localparam logic signed [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
  localparam logic signed [WIDTH:0] W_MAX = (WIDTH+1)'(2**(WIDTH-1) - 1);
  localparam logic signed [WIDTH:0] W_MIN = (WIDTH+1)'(-(2**(WIDTH-1)));

  typedef enum logic [2:0] {IDLE, BASE_EVAL, BASE_CAP, PERTURB, TRY_EVAL, TRY_CAP, DONE} state_t;

  state_t                  state;
  logic signed [WIDTH-1:0] w [N_W];
  logic [N_W-1:0]          dir;
  logic [K_W-1:0]          k;
  logic [C_W-1:0]          cnt;
  logic [7:0]              iters_q;
  logic signed [WIDTH-1:0] old_w;
  logic signed [WIDTH-1:0] cur;
  logic signed [WIDTH:0]   wide;
  logic signed [WIDTH-1:0] cand;
  logic [7:0]              iter_next;
  logic                    last;
  logic [K_W-1:0]          k_next;

  genvar i;
  generate
    for (i = 0; i < N_W; i++) begin : g_flat
      assign w_flat_o[i*WIDTH +: WIDTH] = w[i];
    end
  endgenerate

  // one extra bit of headroom so the step can be clamped instead of wrapping
  always_comb begin
    cur = w[k];
    wide = dir[k] ? $signed({cur[WIDTH-1], cur}) - STEP_X : $signed({cur[WIDTH-1], cur}) + STEP_X;
    cand = wide > W_MAX ? W_MAX[WIDTH-1:0] : wide < W_MIN ? W_MIN[WIDTH-1:0] : wide[WIDTH-1:0];
    iter_next = iter_o + 8'd1;
    last = iter_next == iters_q;
    k_next = k == K_W'(N_W - 1) ? '0 : k + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      for (int n = 0; n < N_W; n++) w[n] <= '0;
      dir <= '0;
      k <= '0;
      cnt <= '0;
      iters_q <= '0;
      old_w <= '0;
      fwd_en_o <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      best_loss_o <= '0;
      iter_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (init_load_i && 32'(init_idx_i) < N_W) w[init_idx_i[K_W-1:0]] <= init_w_i;
          if (start_i) begin
            state <= BASE_EVAL;
            busy_o <= 1'b1;
            fwd_en_o <= 1'b1;
            cnt <= '0;
            iter_o <= '0;
            k <= '0;
            iters_q <= iters_i;
          end
        end
        BASE_EVAL, TRY_EVAL: begin
          cnt <= cnt + 1'b1;
          if (cnt == C_W'(FWD_LAT - 1)) begin
            fwd_en_o <= 1'b0;
            state <= state == BASE_EVAL ? BASE_CAP : TRY_CAP;
          end
        end
        BASE_CAP: begin
          best_loss_o <= loss_i;
          state <= iters_q == '0 ? DONE : PERTURB;
          done_o <= iters_q == '0;
        end
        PERTURB: begin
          old_w <= cur;
          if (cand == cur) begin
            dir[k] <= ~dir[k];
            k <= k_next;
            iter_o <= iter_next;
            state <= last ? DONE : PERTURB;
            done_o <= last;
          end else begin
            w[k] <= cand;
            fwd_en_o <= 1'b1;
            cnt <= '0;
            state <= TRY_EVAL;
          end
        end
        TRY_CAP: begin
          if (loss_i < best_loss_o) begin
            best_loss_o <= loss_i;
          end else begin
            w[k] <= old_w;
            dir[k] <= ~dir[k];
          end
          k <= k_next;
          iter_o <= iter_next;
          state <= last ? DONE : PERTURB;
          done_o <= last;
        end
        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nn_perturb_train_ctrl.sv
// tb_nn_perturb_train_ctrl: directed checks of the perturbation training sequencer
module tb_nn_perturb_train_ctrl;
  logic        clk = 0;
  logic        rst_i = 1;
  logic        start_i = 0;
  logic [7:0]  iters_i = 0;
  logic        init_load_i = 0;
  logic [3:0]  init_idx_i = 0;
  logic [7:0]  init_w_i = 0;
  logic [41:0] loss_i;
  logic        fwd_en_o;
  logic [79:0] w_flat_o;
  logic        busy_o;
  logic        done_o;
  logic [41:0] best_loss_o;
  logic [7:0]  iter_o;
  int          mode = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          d_at, f_cyc;
  logic [79:0] pw;

  nn_perturb_train_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .iters_i(iters_i),
    .init_load_i(init_load_i), .init_idx_i(init_idx_i), .init_w_i(init_w_i),
    .loss_i(loss_i), .fwd_en_o(fwd_en_o), .w_flat_o(w_flat_o), .busy_o(busy_o),
    .done_o(done_o), .best_loss_o(best_loss_o), .iter_o(iter_o)
  );

  always #5 clk = ~clk;

  // datapath stand-in: constant 100, 100-w0, or constant 50
  always_comb begin
    loss_i = mode == 0 ? 42'd100 : mode == 1 ? 42'(100 - int'($signed(w_flat_o[7:0]))) : 42'd50;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0] idx, input logic [7:0] v);
    init_load_i = 1;
    init_idx_i = idx;
    init_w_i = v;
    tick();
    init_load_i = 0;
  endtask

  // c counts cycles after the start edge: c=1 is T+1
  task automatic run(input logic [7:0] n, input int probe, input bit poke,
                     output int done_at, output int fwd_cyc, output logic [79:0] pw_o);
    iters_i = n;
    start_i = 1;
    tick();
    start_i = 0;
    done_at = -1;
    fwd_cyc = 0;
    pw_o = 'x;
    for (int c = 1; c <= 300; c++) begin
      if (fwd_en_o) fwd_cyc++;
      if (c == probe) pw_o = w_flat_o;
      if (done_o) begin
        done_at = c;
        break;
      end
      if (poke && c == 3) begin
        start_i = 1;
        init_load_i = 1;
        init_idx_i = 0;
        init_w_i = 8'hF9;
      end else begin
        start_i = 0;
        init_load_i = 0;
      end
      tick();
    end
    start_i = 0;
    init_load_i = 0;
  endtask

  initial begin
    tick();
    tick();
    rst_i = 0;
    chk("rst_busy", 80'(busy_o), 80'd0);
    chk("rst_fwd", 80'(fwd_en_o), 80'd0);
    chk("rst_done", 80'(done_o), 80'd0);
    chk("rst_w", w_flat_o, 80'd0);
    chk("rst_best", 80'(best_loss_o), 80'd0);
    chk("rst_iter", 80'(iter_o), 80'd0);

    load(4'd0, 8'd5);
    chk("load_w0", w_flat_o, 80'd5);
    load(4'd12, 8'd33);
    chk("load_oob", w_flat_o, 80'd5);

    mode = 0;
    run(8'd0, 0, 0, d_at, f_cyc, pw);
    chk("it0_done_at", 80'(d_at), 80'd6);
    chk("it0_fwd", 80'(f_cyc), 80'd4);
    chk("it0_best", 80'(best_loss_o), 80'd100);
    chk("it0_w", w_flat_o, 80'd5);
    chk("it0_busy_in_done", 80'(busy_o), 80'd1);
    tick();
    chk("it0_busy_after", 80'(busy_o), 80'd0);
    chk("it0_done_pulse", 80'(done_o), 80'd0);

    mode = 1;
    run(8'd1, 7, 0, d_at, f_cyc, pw);
    chk("acc_done_at", 80'(d_at), 80'd12);
    chk("acc_fwd", 80'(f_cyc), 80'd8);
    chk("acc_probe_w", pw, 80'd6);
    chk("acc_w", w_flat_o, 80'd6);
    chk("acc_best", 80'(best_loss_o), 80'd94);
    chk("acc_iter", 80'(iter_o), 80'd1);
    tick();

    load(4'd0, 8'd5);
    mode = 2;
    run(8'd1, 7, 0, d_at, f_cyc, pw);
    chk("rej_done_at", 80'(d_at), 80'd12);
    chk("rej_probe_w", pw, 80'd6);
    chk("rej_w", w_flat_o, 80'd5);
    chk("rej_best", 80'(best_loss_o), 80'd50);
    tick();
    run(8'd1, 7, 0, d_at, f_cyc, pw);
    chk("rej2_probe_w", pw, 80'd4);
    chk("rej2_w", w_flat_o, 80'd5);
    chk("rej2_done_at", 80'(d_at), 80'd12);
    tick();

    load(4'd0, 8'd127);
    run(8'd1, 0, 0, d_at, f_cyc, pw);
    chk("sat_done_at", 80'(d_at), 80'd7);
    chk("sat_fwd", 80'(f_cyc), 80'd4);
    chk("sat_w", w_flat_o, 80'd127);
    chk("sat_iter", 80'(iter_o), 80'd1);
    tick();
    run(8'd1, 7, 0, d_at, f_cyc, pw);
    chk("sat_dirflip_probe", pw, 80'd126);
    chk("sat_dirflip_w", w_flat_o, 80'd127);
    tick();

    load(4'd0, 8'd0);
    run(8'd12, 67, 1, d_at, f_cyc, pw);
    chk("wrap_done_at", 80'(d_at), 80'd78);
    chk("wrap_fwd", 80'(f_cyc), 80'd52);
    chk("wrap_probe_k0_again", pw, 80'hFF);
    chk("wrap_iter", 80'(iter_o), 80'd12);
    chk("wrap_w", w_flat_o, 80'd0);
    chk("wrap_best", 80'(best_loss_o), 80'd50);
    tick();
    chk("wrap_busy_after", 80'(busy_o), 80'd0);

    load(4'd0, 8'd5);
    iters_i = 3;
    start_i = 1;
    tick();
    start_i = 0;
    for (int c = 1; c < 8; c++) tick();
    chk("pre_rst_fwd", 80'(fwd_en_o), 80'd1);
    rst_i = 1;
    tick();
    rst_i = 0;
    chk("mid_rst_busy", 80'(busy_o), 80'd0);
    chk("mid_rst_fwd", 80'(fwd_en_o), 80'd0);
    chk("mid_rst_done", 80'(done_o), 80'd0);
    chk("mid_rst_w", w_flat_o, 80'd0);
    chk("mid_rst_best", 80'(best_loss_o), 80'd0);
    chk("mid_rst_iter", 80'(iter_o), 80'd0);
    mode = 1;
    run(8'd1, 0, 0, d_at, f_cyc, pw);
    chk("post_rst_done_at", 80'(d_at), 80'd12);
    chk("post_rst_w", w_flat_o, 80'd1);
    chk("post_rst_best", 80'(best_loss_o), 80'd99);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/nn_perturb_train_ctrl.md
# nn_perturb_train_ctrl

Training sequencer for the two-hidden/one-output neuron datapath. Owns the 10-entry weight bank (8 hidden, 2 output), drives the forward-pass enable and samples the datapath loss. Runs weight-perturbation learning: perturb one weight by ±STEP, re-evaluate, keep the change only if loss strictly drops. Sits between the top-level I/O and the neuron instances, replacing their hard-wired weights and constant enables.

## Interface

- WIDTH, 8: signed weight width.
- N_W, 10: number of weights; index k=0..7 hidden (hn0 w0..w3, hn1 w0..w3), 8..9 output w0/w1.
- LOSS_W, 42: loss width, unsigned.
- FWD_LAT, 4: cycles `fwd_en_o` is held per forward pass, ≥1.
- STEP, 1: perturbation magnitude, positive.

Ports:
- clk_i  in  1  single clock; everything on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  start a run; sampled only in IDLE.
- iters_i  in  8  number of trials for the run; latched at start.
- init_load_i  in  1  write `init_w_i` to `w[init_idx_i]`; honoured only in IDLE; index ≥N_W ignored.
- init_idx_i  in  4  weight index for load.
- init_w_i  in  WIDTH  signed load value.
- loss_i  in  LOSS_W  datapath loss; valid the cycle after `fwd_en_o` falls.
- fwd_en_o  out  1  enable to all neurons during a forward pass.
- w_flat_o  out  N_W*WIDTH  weight bank, w[k] at bits [k*WIDTH +: WIDTH].
- busy_o  out  1  high from the cycle after start acceptance through DONE.
- done_o  out  1  one-cycle pulse when the run finishes.
- best_loss_o  out  LOSS_W  last accepted (baseline or improved) loss.
- iter_o  out  8  trials completed in current/last run.

## Operation

- States: IDLE, BASE_EVAL, BASE_CAP, PERTURB, TRY_EVAL, TRY_CAP, DONE.
- IDLE: `start_i` → BASE_EVAL; clear `iter_o`, index k=0, latch `iters_i`. `init_load_i` in the same cycle as `start_i` is still performed. `start_i` and `init_load_i` outside IDLE are ignored.
- BASE_EVAL: `fwd_en_o`=1 for FWD_LAT cycles, then BASE_CAP.
- BASE_CAP: `best_loss_o` ← `loss_i`. If latched iters=0, go to DONE; otherwise go to PERTURB.
- PERTURB: candidate = w[k] + (dir[k] ? −STEP : +STEP), saturated to [−2^(WIDTH−1), 2^(WIDTH−1)−1]. Save old w[k].
  - If candidate == old (saturated): flip dir[k], k←k+1 mod N_W, iter+1. Go to DONE if iter reaches iters, else stay in PERTURB.
  - Otherwise: w[k] ← candidate, go to TRY_EVAL.
- TRY_EVAL: same as BASE_EVAL, then TRY_CAP.
- TRY_CAP:
  - If `loss_i` < `best_loss_o` (unsigned, strict): accept, `best_loss_o` ← `loss_i`, dir[k] unchanged.
  - Otherwise (including tie): w[k] ← old, flip dir[k].
  - Then k←k+1 mod N_W (9 wraps to 0), iter+1. Go to DONE if iter==iters, else PERTURB.
- DONE: `done_o`=1 for one cycle, then IDLE.
- dir[k] (0 = +, 1 = −) persists across runs; cleared only by reset.
- Reset (any state, mid-run included): state IDLE; all w=0; all dir=0; `fwd_en_o`, `busy_o`, `done_o`=0; `best_loss_o`=0; `iter_o`=0; k=0.

## Timing

- Start sampled in cycle T. `busy_o`=1 and `fwd_en_o`=1 in T+1..T+FWD_LAT. BASE_CAP is at T+FWD_LAT+1.
- Normal trial: PERTURB 1 cycle + FWD_LAT cycles of `fwd_en_o` + TRY_CAP 1 cycle = FWD_LAT+2 cycles. The weight change is visible on `w_flat_o` the cycle `fwd_en_o` rises.
- Saturated trial: 1 cycle, no `fwd_en_o`.
- `done_o` at T+FWD_LAT+2+Σtrial lengths. `busy_o` falls the cycle after `done_o`.
- Defaults, iters=0: `done_o` at T+6.
- Defaults, all trials normal: `done_o` at T+6+6·iters.
- `w_flat_o`, `best_loss_o` and `iter_o` are registered and stable outside their update cycles.

## Test plan

- Reset: assert `rst_i` mid-TRY_EVAL → next cycle IDLE, `w_flat_o`=0, `busy_o`/`fwd_en_o`/`done_o`=0, `best_loss_o`=0; a new start then runs normally.
- iters=0: load w0=5, datapath model returns loss=100, start at T → `fwd_en_o` high T+1..T+4, `done_o` at T+6, `best_loss_o`=100, w0 unchanged.
- Accept: loss=100−w0, w0=5, iters=1 → w0=6, `best_loss_o`=94, dir[0]=+, `iter_o`=1, `done_o` at T+12.
- Reject/tie: constant loss=50, w0=5, iters=1 → w0 back to 5, dir[0]=−. A second run with iters=1 tries w0=4 (visible during `fwd_en_o`), rejects, and restores 5.
- Saturation: w0=127, dir+, iters=1 → no second `fwd_en_o` burst, dir[0] flips, w0=127, `done_o` at T+7.
- Wrap/busy: iters=12 → k visits 0..9,0,1, `iter_o`=12. `start_i` and `init_load_i` pulsed while busy have no effect.
